// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the pipeline sequencing unit.
package pipeline_pkg;

   // Sequencer states; encoding is visible on state_o.
   typedef enum logic [1:0] {
      StRseq   = 2'd0,
      StRun    = 2'd1,
      StDrain  = 2'd2,
      StHalted = 2'd3
   } pipe_state_t;

   // Per-stage register update select.
   typedef enum logic [1:0] {
      SelHold   = 2'd0,
      SelLoad   = 2'd1,
      SelBubble = 2'd2
   } stage_sel_t;

   localparam int unsigned DefaultNopWord = 0;

   // Low bit index of stage k inside a flattened instruction bus.
   function automatic int unsigned stage_lo(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: instruction word plus valid bit with hold/load/bubble select.
module pipe_stage_reg
   import pipeline_pkg::*;
#(
   parameter int unsigned       IR_W     = 16,
   parameter logic [IR_W-1:0]   NOP_WORD = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  stage_sel_t      sel_i,
   input  logic [IR_W-1:0] word_i,
   input  logic            valid_i,
   output logic [IR_W-1:0] word_o,
   output logic            valid_o
);

   logic [IR_W-1:0] word_q;
   logic            valid_q;

   // Stage register; reset and bubble both load the NOP encoding as invalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q  <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         unique case (sel_i)
            SelLoad: begin
               word_q  <= word_i;
               valid_q <= valid_i;
            end
            SelBubble: begin
               word_q  <= NOP_WORD;
               valid_q <= 1'b0;
            end
            default: begin
               word_q  <= word_q;
               valid_q <= valid_q;
            end
         endcase
      end
   end

   assign word_o  = word_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: staged reset release, stall/flush bubbles, drain-then-freeze halt.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned     STAGES      = 3,
   parameter int unsigned     IR_W        = 16,
   parameter logic [IR_W-1:0] NOP_WORD    = IR_W'(DefaultNopWord),
   parameter int unsigned     FLUSH_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [IR_W-1:0]        ir_fetch,
   input  logic                   fetch_valid,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   halt_req,
   input  logic                   resume,
   output logic                   fetch_en,
   output logic [STAGES*IR_W-1:0] ir_stage,
   output logic [STAGES-1:0]      valid_stage,
   output logic [STAGES-1:0]      stage_rst,
   output logic                   halted,
   output logic [1:0]             state_o
);

   localparam int unsigned CntW = $clog2(STAGES + 1);

   pipe_state_t     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            halted_q;

   logic [IR_W-1:0]   word_q    [STAGES];
   logic [IR_W-1:0]   src_word  [STAGES];
   logic [STAGES-1:0] src_valid;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   stage_sel_t        sel       [STAGES];

   assign fetch_en = (state_q == StRun) & (~stall | flush);

   // Stage update select: flush beats stall; drain feeds bubbles into stage 0.
   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         sel[k] = SelHold;
      end
      unique case (state_q)
         StRseq: begin
            for (int unsigned k = 0; k < STAGES; k++) begin
               sel[k] = SelBubble;
            end
         end
         StRun, StDrain: begin
            for (int unsigned k = 0; k < STAGES; k++) begin
               if (flush && (k < FLUSH_DEPTH)) begin
                  sel[k] = SelBubble;
               end else if (!flush && stall && (k == 0)) begin
                  sel[k] = SelHold;
               end else if (!flush && stall && (k == 1)) begin
                  sel[k] = SelBubble;
               end else if ((k == 0) && (state_q == StDrain)) begin
                  sel[k] = SelBubble;
               end else begin
                  sel[k] = SelLoad;
               end
            end
         end
         default: ;
      endcase
   end

   // Next-cycle valid bits, needed to detect an empty pipe while draining.
   always_comb begin
      valid_d = valid_q;
      for (int unsigned k = 0; k < STAGES; k++) begin
         unique case (sel[k])
            SelLoad:   valid_d[k] = src_valid[k];
            SelBubble: valid_d[k] = 1'b0;
            default:   valid_d[k] = valid_q[k];
         endcase
      end
   end

   // Sequencer next state and reset-release counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRseq: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(STAGES - 1)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (halt_req) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (valid_d == '0) begin
               state_d = StHalted;
            end
         end
         StHalted: begin
            if (resume) begin
               state_d = StRun;
            end
         end
         default: state_d = StRseq;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StRseq;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= (state_d == StHalted);
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src_fetch
         assign src_word[k]  = ir_fetch;
         assign src_valid[k] = fetch_valid & fetch_en;
      end else begin : g_src_prev
         assign src_word[k]  = word_q[k-1];
         assign src_valid[k] = valid_q[k-1];
      end

      pipe_stage_reg #(
         .IR_W     (IR_W),
         .NOP_WORD (NOP_WORD)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .sel_i   (sel[k]),
         .word_i  (src_word[k]),
         .valid_i (src_valid[k]),
         .word_o  (word_q[k]),
         .valid_o (valid_q[k])
      );

      assign ir_stage[stage_lo(k, IR_W) +: IR_W] = word_q[k];
      // Stage k leaves reset once k+1 edges have elapsed since reset fell.
      assign stage_rst[k] = (cnt_q <= CntW'(k));
   end

   assign valid_stage = valid_q;
   assign halted      = halted_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised + directed bench for pipeline_ctrl with a queue-based scoreboard.
module tb_pipeline_ctrl;

   localparam int unsigned STAGES = 3;
   localparam int unsigned IR_W   = 16;
   localparam int unsigned FD     = 2;
   localparam logic [15:0] NOP    = 16'h0000;

   logic                   clk;
   logic                   reset;
   logic [IR_W-1:0]        ir_fetch;
   logic                   fetch_valid;
   logic                   stall;
   logic                   flush;
   logic                   halt_req;
   logic                   resume;
   logic                   fetch_en;
   logic [STAGES*IR_W-1:0] ir_stage;
   logic [STAGES-1:0]      valid_stage;
   logic [STAGES-1:0]      stage_rst;
   logic                   halted;
   logic [1:0]             state_o;

   pipeline_ctrl #(
      .STAGES      (STAGES),
      .IR_W        (IR_W),
      .NOP_WORD    (NOP),
      .FLUSH_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ir_fetch    (ir_fetch),
      .fetch_valid (fetch_valid),
      .stall       (stall),
      .flush       (flush),
      .halt_req    (halt_req),
      .resume      (resume),
      .fetch_en    (fetch_en),
      .ir_stage    (ir_stage),
      .valid_stage (valid_stage),
      .stage_rst   (stage_rst),
      .halted      (halted),
      .state_o     (state_o)
   );

   typedef struct {
      logic        fe;
      logic [47:0] ir;
      logic [2:0]  vld;
      logic [2:0]  rst;
      logic        hlt;
      logic [1:0]  st;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: stage contents as plain arrays, state as a number 0..3.
   logic [15:0] m_word [STAGES];
   logic        m_vld  [STAGES];
   int          m_state;
   int          m_rel;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   // Monitor: compares each cycle's DUT outputs with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fetch_en", 64'(fetch_en), 64'(e.fe));
            check("ir_stage", 64'(ir_stage), 64'(e.ir));
            check("valid_stage", 64'(valid_stage), 64'(e.vld));
            check("stage_rst", 64'(stage_rst), 64'(e.rst));
            check("halted", 64'(halted), 64'(e.hlt));
            check("state_o", 64'(state_o), 64'(e.st));
         end
      end
   end

   task automatic model_reset();
      for (int k = 0; k < STAGES; k++) begin
         m_word[k] = NOP;
         m_vld[k]  = 1'b0;
      end
      m_state = 0;
      m_rel   = 0;
   endtask

   // One clock: apply inputs, record expected outputs for this cycle, advance model.
   task automatic cycle(input logic r, input logic fv, input logic [15:0] ir,
                        input logic st, input logic fl, input logic hr, input logic rs);
      exp_t        e;
      logic        fe;
      logic [15:0] nw [STAGES];
      logic        nv [STAGES];
      bit          empty;
      @(posedge clk);
      #2;
      reset = r; fetch_valid = fv; ir_fetch = ir;
      stall = st; flush = fl; halt_req = hr; resume = rs;

      fe = (m_state == 1) && (!st || fl);
      e.fe = fe;
      for (int k = 0; k < STAGES; k++) begin
         e.ir[k*16 +: 16] = m_word[k];
         e.vld[k]         = m_vld[k];
         e.rst[k]         = (m_rel <= k);
      end
      e.hlt = (m_state == 3);
      e.st  = 2'(m_state);
      exp_q.push_back(e);

      if (r) begin
         model_reset();
      end else if (m_state == 0) begin
         m_rel++;
         if (m_rel == STAGES) m_state = 1;
      end else if (m_state == 3) begin
         if (rs) m_state = 1;
      end else begin
         if (m_state == 1) begin
            nw[0] = ir;
            nv[0] = fv && fe;
         end else begin
            nw[0] = NOP;
            nv[0] = 1'b0;
         end
         for (int k = 1; k < STAGES; k++) begin
            nw[k] = m_word[k-1];
            nv[k] = m_vld[k-1];
         end
         if (fl) begin
            for (int k = 0; k < FD; k++) begin
               nw[k] = NOP;
               nv[k] = 1'b0;
            end
         end else if (st) begin
            nw[0] = m_word[0];
            nv[0] = m_vld[0];
            nw[1] = NOP;
            nv[1] = 1'b0;
         end
         empty = 1'b1;
         for (int k = 0; k < STAGES; k++) begin
            m_word[k] = nw[k];
            m_vld[k]  = nv[k];
            if (nv[k]) empty = 1'b0;
         end
         if (m_state == 1 && hr) m_state = 2;
         else if (m_state == 2 && empty) m_state = 3;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fetch(input logic [15:0] w);
      cycle(1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; fetch_valid = 1'b0; ir_fetch = '0;
      stall = 1'b0; flush = 1'b0; halt_req = 1'b0; resume = 1'b0;
      model_reset();

      // Reset release sequence.
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);
      // Straight flow.
      fetch(16'h1111); fetch(16'h2222); fetch(16'h3333);
      idle(1);
      // Single stall with stage0=A, stage1=B.
      fetch(16'h000B); fetch(16'h000A);
      cycle(1'b0, 1'b1, 16'h0C0C, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      // Flush together with stall.
      fetch(16'h0003); fetch(16'h0002); fetch(16'h0001);
      cycle(1'b0, 1'b1, 16'h0D0D, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      // Halt, drain, resume.
      fetch(16'h0101); fetch(16'h0202); fetch(16'h0303);
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(5);
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      fetch(16'h0404);
      // Halt with flush on the same edge.
      fetch(16'h0505);
      cycle(1'b0, 1'b1, 16'h0606, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Reset in the middle of a drain.
      fetch(16'h0707); fetch(16'h0808); fetch(16'h0909);
      cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 70),
               16'($urandom),
               ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < 10),
               ($urandom_range(0, 99) < 6),
               ($urandom_range(0, 99) < 30));
      end
      idle(1);

      @(posedge clk);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
